// File: rtl/uart_fifo_mmio.sv
// rtl/uart_fifo_mmio.sv - buffered 8N1 UART peripheral for the picorv32 native bus
// TX/RX FIFOs behind a DATA/STATUS/LEVEL register window with one-cycle acknowledge.

module uart_fifo_mmio_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic [8:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [8:0]    count_q;
    logic          do_push, do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != 9'd0);
    assign do_push = push_i && ((count_q != 9'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 9'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {8'd0, do_push} - {8'd0, do_pop};
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == 9'(DEPTH));
    assign empty_o = (count_q == 9'd0);
endmodule

module uart_fifo_mmio #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [3:0]  cpu_addr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int         DIV       = CLK_FREQ / BAUD;
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(DIV / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

    logic        ready_q;
    logic [31:0] rdata_q, rdata_d;
    logic        txovf_q, txovf_d, rxovr_q, rxovr_d, frerr_q, frerr_d;

    logic        accept, is_write, tx_push, rx_pop, w1c;
    logic [1:0]  reg_sel;
    logic [7:0]  status;

    logic [7:0]  tx_head, rx_head;
    logic [8:0]  tx_count, rx_count;
    logic        tx_full, tx_empty, rx_full, rx_empty;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_pop, tx_busy;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_push, rx_frerr;

    logic        unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], cpu_wdata[31:8], tx_count[8], rx_count[8]};

    // A request is taken only while no acknowledge is pending, so a held cpu_valid never repeats it.
    assign accept   = cpu_valid && !ready_q;
    assign is_write = |cpu_wstrb;
    assign reg_sel  = cpu_addr[3:2];
    assign tx_push  = accept && (reg_sel == 2'd0) && cpu_wstrb[0];
    assign rx_pop   = accept && (reg_sel == 2'd0) && !is_write && !rx_empty;
    assign w1c      = accept && (reg_sel == 2'd1) && cpu_wstrb[0];
    assign tx_busy  = (tx_state_q != TX_IDLE);
    assign status   = {txovf_q, frerr_q, rxovr_q, tx_busy, rx_full, !rx_empty, tx_empty, tx_full};

    uart_fifo_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk_i(clk), .rst_i(rst), .push_i(tx_push), .wdata_i(cpu_wdata[7:0]), .pop_i(tx_pop),
        .rdata_o(tx_head), .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
    );

    uart_fifo_mmio_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk_i(clk), .rst_i(rst), .push_i(rx_push), .wdata_i(rx_shift_q), .pop_i(rx_pop),
        .rdata_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        rdata_d = 32'd0;
        if (accept && !is_write) begin
            case (reg_sel)
                2'd0: if (!rx_empty) rdata_d = {23'd0, 1'b1, rx_head};
                2'd1: rdata_d = {24'd0, status};
                2'd2: rdata_d = {16'd0, rx_count[7:0], tx_count[7:0]};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as its clear keeps the flag set.
    always_comb begin
        txovf_d = (txovf_q && !(w1c && cpu_wdata[7])) || (tx_push && tx_full && !tx_pop);
        rxovr_d = (rxovr_q && !(w1c && cpu_wdata[5])) || (rx_push && rx_full && !rx_pop);
        frerr_d = (frerr_q && !(w1c && cpu_wdata[6])) || rx_frerr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            txovf_q <= 1'b0;
            rxovr_q <= 1'b0;
            frerr_q <= 1'b0;
        end else begin
            ready_q <= accept;
            rdata_q <= rdata_d;
            txovf_q <= txovf_d;
            rxovr_q <= rxovr_d;
            frerr_q <= frerr_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = 16'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // The line is registered from the current state, so it lags the state by one cycle.
    always_comb begin
        case (tx_state_q)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_q[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        rx_frerr   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d = 16'd0;
                    if (rx_s2_q) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frerr   = 1'b1;
                        rx_state_d = RX_WAITHI;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_WAITHI: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end

    assign cpu_ready = ready_q;
    assign cpu_rdata = rdata_q;
    assign uart_tx   = tx_line_q;
endmodule
